tia_fb_writer: RTL and testbench
================================

// Module: tia_fb_writer
// PURPOSE
//  Upstream feeder of the VGA scan-out stage. Takes the Atari TIA pixel stream
//  (160 px/line, 7-bit NTSC colour codes), converts each code to RGB565 through a palette ROM,
//  doubles it horizontally, and writes it into the 320x240 16-bit framebuffer at y*320+x.
//  Single clock domain. A small FIFO absorbs stalls on the framebuffer write port.
// PARAMETERS
//  FB_W        320  framebuffer width in pixels, equal to 2 x SRC_W
//  FB_H        240  framebuffer height in lines; source lines at y >= FB_H are dropped
//  SRC_W       160  TIA pixels per line; source pixels at x >= SRC_W are dropped
//  ADDR_W      17   framebuffer address width
//  FIFO_DEPTH  8    write-FIFO entries (power of 2, >= 4)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       asynchronous, active-low reset
//  pix_valid   in   1       source pixel present
//  pix_color   in   7       TIA colour code: [6:3] hue, [2:0] luma
//  pix_sol     in   1       qualifies the pixel as the first of a new line
//  pix_sof     in   1       qualifies the pixel as the first of a new frame (overrides pix_sol)
//  pix_ready   out  1       block accepts a pixel this cycle
//  fb_we       out  1       write request to framebuffer
//  fb_addr     out  ADDR_W  write address
//  fb_wdata    out  16      RGB565 write data
//  fb_grant    in   1       framebuffer accepts the write this cycle
//  frame_done  out  1       1-cycle pulse when the write at address FB_W*FB_H-1 completes
// BEHAVIOUR
//  - Reset (async assert, sync release): pix_ready=0, fb_we=0, fb_addr=0, fb_wdata=0,
//    frame_done=0. FIFO is emptied, pipeline is invalidated, x=0, y=0, FSM=IDLE.
//    Asserting reset mid-write drops that write and every pending write.
//  - Accept: the block takes a pixel on any cycle with pix_valid && pix_ready.
//    pix_ready=1 iff fifo_count + inflight <= FIFO_DEPTH-1, where inflight is the count of
//    valid pipeline stages (0..2). The FIFO therefore never overflows.
//  - Coordinates of an accepted pixel:
//    - pix_sof: x=0, y=0.
//    - else pix_sol: x=0, y=y+1, saturating at FB_H.
//    - else: x=x+1, saturating at SRC_W.
//    Pixels with x>=SRC_W or y>=FB_H are accepted and discarded; no FIFO entry is made.
//  - Pipeline:
//    - S1 registers colour and coords and computes base = (y<<8)+(y<<6)+(x<<1).
//    - S2 registers palette[pix_color] to RGB565 (synchronous ROM read).
//    - An entry {base, rgb} enters the FIFO 2 cycles after acceptance.
//  - Write FSM:
//    - IDLE: when the FIFO is non-empty, pop an entry into regs and go to WR0.
//    - WR0: fb_we=1, fb_addr=base. On fb_grant go to WR1.
//    - WR1: fb_we=1, fb_addr=base+1, same data. On fb_grant, pop the next entry and go to WR0
//      if the FIFO is non-empty, otherwise go to IDLE.
//    - fb_addr, fb_wdata and fb_we stay stable while fb_we=1 && !fb_grant.
//  - Throughput: one source pixel every 2 cycles at full grant (2 writes per pixel).
//  - frame_done pulses in the cycle after the granted write to FB_W*FB_H-1 (76799).
//  - Address width: all address arithmetic is 17-bit unsigned with no wrap. The maximum
//    address is 76799.
//  - A pix_sof arriving while writes are pending does not flush them; prior-frame writes
//    complete in order.
//  - Simultaneous FIFO push (from S2) and pop (from FSM) in one cycle is legal;
//    fifo_count is unchanged.
// STRUCTURE
//  - Shared package video_pkg holds:
//    - FB_W, FB_H, SRC_W and ADDR_W constants.
//    - the 128x16 NTSC-to-RGB565 palette table.
//    - the FSM state encoding {IDLE, WR0, WR1}.
//  - Sub-module fb_wr_fifo: synchronous FIFO, width ADDR_W+16, depth FIFO_DEPTH, with count
//    output and async active-low reset.
//  - Top level holds the coordinate counters, the 2-stage pipeline and the write FSM.
// TESTING
//  1. Reset release, pix_valid=0 -> pix_ready=1 the next cycle; fb_we=0; frame_done=0.
//  2. pix_sof with code 7'h0E, fb_grant tied 1 -> writes at addr 0 and addr 1, both with
//     data palette[0x0E], on consecutive cycles.
//  3. pix_sol at line 1, then 3 pixels -> pixel x=2 writes addresses 324 and 325.
//  4. fb_grant=0 for 40 cycles under continuous input ->
//     - pix_ready deasserts with fifo_count + inflight = FIFO_DEPTH.
//     - fb_addr and fb_wdata stay stable.
//     - no pixel is lost after fb_grant returns.
//  5. Full 160x240 frame with grant=1 -> exactly 76800 writes; frame_done fires once, after
//     addr 76799. A 241st line produces no writes.
//  6. Reset asserted while in WR1 with 3 FIFO entries -> fb_we=0 immediately; no writes
//     occur after release.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants, write-FSM state encoding and the NTSC colour palette
// used by the TIA-to-framebuffer writer.
package video_pkg;

    localparam int FB_W   = 320;
    localparam int FB_H   = 240;
    localparam int SRC_W  = 160;
    localparam int ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } wr_state_t;

    // Indexed directly by the TIA code: row = hue [6:3], column = luma [2:0].
    localparam logic [23:0] NTSC_RGB888 [128] = '{
        24'h000000, 24'h404040, 24'h6c6c6c, 24'h909090, 24'hb0b0b0, 24'hc8c8c8, 24'hdcdcdc, 24'hececec,
        24'h444400, 24'h646410, 24'h848424, 24'ha0a034, 24'hb8b840, 24'hd0d050, 24'he8e85c, 24'hfcfc68,
        24'h702800, 24'h844414, 24'h985c28, 24'hac783c, 24'hbc8c4c, 24'hcca05c, 24'hdcb468, 24'hecc878,
        24'h841800, 24'h983418, 24'hac5030, 24'hc06848, 24'hd0805c, 24'he09470, 24'heca880, 24'hfcbc94,
        24'h880000, 24'h9c2020, 24'hb03c3c, 24'hc05858, 24'hd07070, 24'he08888, 24'heca0a0, 24'hfcb4b4,
        24'h78005c, 24'h8c2074, 24'ha03c88, 24'hb0589c, 24'hc070b0, 24'hd084c0, 24'hdc9cd0, 24'hecb0e0,
        24'h480078, 24'h602090, 24'h783ca4, 24'h8c58b8, 24'ha070cc, 24'hb484dc, 24'hc49cec, 24'hd4b0fc,
        24'h140084, 24'h302098, 24'h4c3cac, 24'h6858c0, 24'h7c70d0, 24'h9488e0, 24'ha8a0ec, 24'hbcb4fc,
        24'h000088, 24'h1c209c, 24'h3840b0, 24'h505cc0, 24'h6874d0, 24'h7c8ce0, 24'h90a4ec, 24'ha4b8fc,
        24'h00187c, 24'h1c3890, 24'h3854a8, 24'h5070bc, 24'h6888cc, 24'h7c9cdc, 24'h90b4ec, 24'ha4c8fc,
        24'h002c5c, 24'h1c4c78, 24'h386890, 24'h5084ac, 24'h689cc0, 24'h7cb4d4, 24'h90cce8, 24'ha4e0fc,
        24'h003c2c, 24'h1c5c48, 24'h387c64, 24'h509c80, 24'h68b494, 24'h7cd0ac, 24'h90e4c0, 24'ha4fcd4,
        24'h003c00, 24'h205c20, 24'h407c40, 24'h5c9c5c, 24'h74b474, 24'h8cd08c, 24'ha4e4a4, 24'hb8fcb8,
        24'h143800, 24'h345c1c, 24'h507c38, 24'h6c9850, 24'h84b468, 24'h9ccc7c, 24'hb4e490, 24'hc8fca4,
        24'h2c3000, 24'h4c501c, 24'h687034, 24'h848c4c, 24'h9ca864, 24'hb4c078, 24'hccd488, 24'he0ec9c,
        24'h442800, 24'h644818, 24'h846830, 24'ha08444, 24'hb89c58, 24'hd0b46c, 24'he8cc7c, 24'hfce08c
    };

    function automatic logic [15:0] palette_rgb565(input logic [6:0] code);
        return {NTSC_RGB888[code][23:19], NTSC_RGB888[code][15:10], NTSC_RGB888[code][7:3]};
    endfunction

endpackage

// File: rtl/tia_fb_writer_if.sv
// Pixel-stream input and framebuffer write port of the TIA framebuffer writer.
interface tia_fb_writer_if;
    import video_pkg::*;

    logic              pix_valid;
    logic [6:0]        pix_color;
    logic              pix_sol;
    logic              pix_sof;
    logic              pix_ready;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_wdata;
    logic              fb_grant;
    logic              frame_done;

    // master: pixel source plus framebuffer arbiter; slave: the writer itself
    modport master (
        output pix_valid, pix_color, pix_sol, pix_sof, fb_grant,
        input  pix_ready, fb_we, fb_addr, fb_wdata, frame_done
    );

    modport slave (
        input  pix_valid, pix_color, pix_sol, pix_sof, fb_grant,
        output pix_ready, fb_we, fb_addr, fb_wdata, frame_done
    );

endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO buffering {address, rgb565} entries between the pixel
// pipeline and the framebuffer write FSM; rdata shows the head entry.
module fb_wr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tia_fb_writer.sv
// TIA pixel stream to 320x240 RGB565 framebuffer writer: coordinate tracking,
// palette pipeline, write FIFO and a two-writes-per-pixel write FSM.
//
//   state | meaning
//   IDLE  | nothing loaded, waiting for a FIFO entry
//   WR0   | writing left (even) pixel at base
//   WR1   | writing right (odd) pixel at base+1
module tia_fb_writer
    import video_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input logic            clk,
    input logic            reset,
    tia_fb_writer_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
    localparam logic [8:0] X_SAT = 9'(SRC_W);
    localparam logic [8:0] Y_SAT = 9'(FB_H);

    logic              ready_en;
    logic [8:0]        x;
    logic [8:0]        y;
    logic [8:0]        nx;
    logic [8:0]        ny;
    logic              accept;
    logic              keep;
    logic [ADDR_W-1:0] base_n;

    logic              s1_v;
    logic [6:0]        s1_color;
    logic [ADDR_W-1:0] s1_base;
    logic              s2_v;
    logic [ADDR_W-1:0] s2_base;
    logic [15:0]       s2_rgb;

    logic [CNT_W-1:0]     fifo_count;
    logic [OCC_W-1:0]     occ;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [ADDR_W+15:0]   fifo_rdata;
    wr_state_t            state;

    // Pipeline stages count against FIFO space so an accepted pixel always has a slot.
    assign occ           = OCC_W'(fifo_count) + OCC_W'(s1_v) + OCC_W'(s2_v);
    assign bus.pix_ready = ready_en && (occ <= OCC_W'(FIFO_DEPTH - 1));
    assign accept        = bus.pix_valid && bus.pix_ready;

    always_comb begin
        nx = x;
        ny = y;
        if (bus.pix_sof) begin
            nx = '0;
            ny = '0;
        end else if (bus.pix_sol) begin
            nx = '0;
            ny = (y >= Y_SAT) ? Y_SAT : y + 9'd1;
        end else begin
            nx = (x >= X_SAT) ? X_SAT : x + 9'd1;
        end
    end

    assign keep   = (nx < X_SAT) && (ny < Y_SAT);
    assign base_n = (ADDR_W'(ny) << 8) + (ADDR_W'(ny) << 6) + (ADDR_W'(nx) << 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
            x        <= '0;
            y        <= '0;
            s1_v     <= 1'b0;
            s1_color <= '0;
            s1_base  <= '0;
            s2_v     <= 1'b0;
            s2_base  <= '0;
            s2_rgb   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                x <= nx;
                y <= ny;
            end
            s1_v <= accept && keep;
            if (accept && keep) begin
                s1_color <= bus.pix_color;
                s1_base  <= base_n;
            end
            s2_v    <= s1_v;
            s2_base <= s1_base;
            s2_rgb  <= palette_rgb565(s1_color);
        end
    end

    assign fifo_empty = (fifo_count == '0);
    assign fifo_pop   = !fifo_empty && ((state == IDLE) || (state == WR1 && bus.fb_grant));

    fb_wr_fifo #(
        .WIDTH(ADDR_W + 16),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (s2_v),
        .wdata({s2_base, s2_rgb}),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .count(fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus.fb_we      <= 1'b0;
            bus.fb_addr    <= '0;
            bus.fb_wdata   <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        bus.fb_addr  <= fifo_rdata[ADDR_W+15:16];
                        bus.fb_wdata <= fifo_rdata[15:0];
                        bus.fb_we    <= 1'b1;
                        state        <= WR0;
                    end
                end
                WR0: begin
                    if (bus.fb_grant) begin
                        bus.frame_done <= (bus.fb_addr == LAST_ADDR);
                        bus.fb_addr    <= bus.fb_addr + ADDR_W'(1);
                        state          <= WR1;
                    end
                end
                WR1: begin
                    if (bus.fb_grant) begin
                        bus.frame_done <= (bus.fb_addr == LAST_ADDR);
                        if (!fifo_empty) begin
                            bus.fb_addr  <= fifo_rdata[ADDR_W+15:16];
                            bus.fb_wdata <= fifo_rdata[15:0];
                            state        <= WR0;
                        end else begin
                            bus.fb_we <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    bus.fb_we <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tia_fb_writer.sv
// Directed bench for tia_fb_writer: vector table of pixels with hand-computed
// addresses/colours, plus stall, reset-abort and full-frame sequences.
module tb_tia_fb_writer;
    import video_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tia_fb_writer_if bus ();

    tia_fb_writer #(.FIFO_DEPTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        sof;
        logic        sol;
        logic [6:0]  color;
        logic [16:0] base;
        logic [15:0] rgb;
    } vec_t;

    vec_t        vecs[8];
    logic [6:0]  codes[6];
    logic [15:0] rgbs[6];

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int n_wr = 0;
    int n_done = 0;
    int acc_cnt = 0;
    logic [32:0] exp_q[$];
    logic [16:0] wr_addr_log[$];
    int          wr_cyc_log[$];
    logic        prev_stall = 1'b0;
    logic        prev_last = 1'b0;
    logic [16:0] prev_addr;
    logic [15:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int base, input logic [15:0] rgb);
        exp_q.push_back({17'(base), rgb});
        exp_q.push_back({17'(base + 1), rgb});
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Caller must be just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic sof, input logic sol, input logic [6:0] code);
        int g;
        g = 0;
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_sol   = sol;
        bus.pix_color = code;
        @(negedge clk);
        while (!bus.pix_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!bus.pix_ready) begin
            check("pix_ready_timeout", bus.pix_ready, 1);
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            acc_cnt++;
            #1;
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_sol   = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("drain_complete", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        sync();
    endtask

    always @(negedge clk) begin
        cycle++;
        if (reset) begin
            if (bus.frame_done || prev_last) check("frame_done_timing", bus.frame_done, prev_last);
            if (bus.frame_done) n_done++;
            if (prev_stall) begin
                check("stall_we", bus.fb_we, 1);
                check("stall_addr", bus.fb_addr, prev_addr);
                check("stall_data", bus.fb_wdata, prev_data);
            end
            prev_stall = 1'b0;
            prev_last  = 1'b0;
            if (bus.fb_we && bus.fb_grant) begin
                logic [32:0] e;
                n_wr++;
                if (wr_addr_log.size() < 64) begin
                    wr_addr_log.push_back(bus.fb_addr);
                    wr_cyc_log.push_back(cycle);
                end
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.fb_addr, e[32:16]);
                    check("wr_data", bus.fb_wdata, e[15:0]);
                end
                prev_last = (bus.fb_addr == 17'd76799);
            end else if (bus.fb_we) begin
                prev_stall = 1'b1;
                prev_addr  = bus.fb_addr;
                prev_data  = bus.fb_wdata;
            end
        end else begin
            prev_stall = 1'b0;
            prev_last  = 1'b0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr0;
        int ndone0;
        vecs[0] = '{1'b1, 1'b0, 7'h0E, 17'd0,   16'hEF4B};
        vecs[1] = '{1'b0, 1'b1, 7'h07, 17'd320, 16'hEF7D};
        vecs[2] = '{1'b0, 1'b0, 7'h22, 17'd322, 16'hB1E7};
        vecs[3] = '{1'b0, 1'b0, 7'h45, 17'd324, 16'h7C7C};
        vecs[4] = '{1'b0, 1'b0, 7'h7F, 17'd326, 16'hFF11};
        vecs[5] = '{1'b0, 1'b1, 7'h00, 17'd640, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 7'h0E, 17'd0,   16'hEF4B};
        vecs[7] = '{1'b1, 1'b1, 7'h22, 17'd0,   16'hB1E7};
        codes = '{7'h0E, 7'h07, 7'h22, 7'h45, 7'h7F, 7'h00};
        rgbs  = '{16'hEF4B, 16'hEF7D, 16'hB1E7, 16'h7C7C, 16'hFF11, 16'h0000};

        bus.pix_valid = 1'b0;
        bus.pix_color = '0;
        bus.pix_sol   = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.fb_grant  = 1'b1;

        // reset values and ready after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_fb_we", bus.fb_we, 0);
        check("rst_fb_addr", bus.fb_addr, 0);
        check("rst_fb_wdata", bus.fb_wdata, 0);
        check("rst_frame_done", bus.frame_done, 0);
        sync();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", bus.pix_ready, 1);
        check("post_rst_we", bus.fb_we, 0);
        check("post_rst_done", bus.frame_done, 0);

        // vector table, grant tied high
        sync();
        for (int i = 0; i < 8; i++) begin
            push_exp(int'(vecs[i].base), vecs[i].rgb);
            send(vecs[i].sof, vecs[i].sol, vecs[i].color);
        end
        drain();
        check("first_wr_addr0", wr_addr_log[0], 0);
        check("first_wr_addr1", wr_addr_log[1], 1);
        check("first_wr_back_to_back", wr_cyc_log[1] - wr_cyc_log[0], 1);
        check("x2_line1_addr_a", wr_addr_log[6], 324);
        check("x2_line1_addr_b", wr_addr_log[7], 325);

        // stall: grant low 40 cycles under continuous input
        bus.fb_grant = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push_exp(2 * i, rgbs[i % 6]);
                    send(i == 0, 1'b0, codes[i % 6]);
                end
            end
            begin
                repeat (40) @(negedge clk);
                check("stall_accept_count", acc_cnt, 9);
                check("stall_ready_low", bus.pix_ready, 0);
                sync();
                bus.fb_grant = 1'b1;
            end
        join
        drain();
        check("stall_all_accepted", acc_cnt, 20);

        // reset while in WR1 with three entries queued
        bus.fb_grant = 1'b0;
        for (int i = 0; i < 4; i++) send(i == 0, 1'b0, codes[i]);
        repeat (8) @(negedge clk);
        check("abort_wr0_we", bus.fb_we, 1);
        check("abort_wr0_addr", bus.fb_addr, 0);
        sync();
        exp_q.push_back({17'd0, rgbs[0]});
        bus.fb_grant = 1'b1;
        sync();
        bus.fb_grant = 1'b0;
        @(negedge clk);
        check("abort_wr1_we", bus.fb_we, 1);
        check("abort_wr1_addr", bus.fb_addr, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_we_drop", bus.fb_we, 0);
        check("abort_ready_drop", bus.pix_ready, 0);
        exp_q.delete();
        nwr0 = n_wr;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.fb_grant = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_writes", n_wr, nwr0);

        // full frame, plus one dropped pixel per line and a 241st/242nd line
        sync();
        nwr0 = n_wr;
        ndone0 = n_done;
        for (int y = 0; y < 240; y++) begin
            for (int x = 0; x <= 160; x++) begin
                if (x < 160) push_exp(y * 320 + 2 * x, rgbs[x % 6]);
                send(y == 0 && x == 0, x == 0 && y > 0, codes[x % 6]);
            end
        end
        for (int x = 0; x < 160; x++) send(1'b0, x == 0, codes[x % 6]);
        for (int x = 0; x < 3; x++) send(1'b0, x == 0, codes[x]);
        drain();
        check("frame_write_count", n_wr - nwr0, 76800);
        check("frame_done_count", n_done - ndone0, 1);
        check("frame_done_total", n_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
